// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: grants the address phase to one master, tracks
// fixed-length bursts and locked sequences, and pipelines the owner into the data phase.
module ahb_arbiter #(
    parameter int NUM_MASTER     = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MASTER_W       = $clog2(NUM_MASTER)
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [NUM_MASTER-1:0] hbusreq,
    input  logic [NUM_MASTER-1:0] hlock,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic                  hready,
    output logic [NUM_MASTER-1:0] hgrant,
    output logic [MASTER_W-1:0]   hmaster,
    output logic [MASTER_W-1:0]   hmaster_data,
    output logic                  hmastlock
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_WRAP4  = 3'd2;
    localparam logic [2:0] BU_INCR4  = 3'd3;
    localparam logic [2:0] BU_WRAP8  = 3'd4;
    localparam logic [2:0] BU_INCR8  = 3'd5;
    localparam logic [2:0] BU_WRAP16 = 3'd6;
    localparam logic [2:0] BU_INCR16 = 3'd7;

    localparam logic [MASTER_W-1:0] DEF_IDX = MASTER_W'(DEFAULT_MASTER);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MASTER_W-1:0]   hmaster_q, hmaster_d;
    logic [MASTER_W-1:0]   hmaster_data_q, hmaster_data_d;
    logic [NUM_MASTER-1:0] hgrant_q, hgrant_d;
    logic                  hmastlock_q, hmastlock_d;

    logic [MASTER_W-1:0]   winner_s;
    logic                  owner_lock_s;
    logic                  owner_req_s;
    logic                  fixed_burst_s;
    logic                  single_incr_s;
    logic                  rearb_s;

    function automatic logic [NUM_MASTER-1:0] onehot(input logic [MASTER_W-1:0] idx);
        logic [NUM_MASTER-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Remaining beats after the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] burst);
        case (burst)
            BU_WRAP4, BU_INCR4:   burst_beats = 4'd3;
            BU_WRAP8, BU_INCR8:   burst_beats = 4'd7;
            BU_WRAP16, BU_INCR16: burst_beats = 4'd15;
            default:              burst_beats = 4'd0;
        endcase
    endfunction

    // Scanned from the far end so the nearest requester after the owner wins.
    function automatic logic [MASTER_W-1:0] rr_winner(input logic [MASTER_W-1:0] owner,
                                                      input logic [NUM_MASTER-1:0] req);
        logic [MASTER_W-1:0] cand;
        logic [MASTER_W-1:0] win;
        win = DEF_IDX;
        for (int i = NUM_MASTER; i >= 1; i--) begin
            cand = MASTER_W'((int'(owner) + i) % NUM_MASTER);
            win  = req[cand] ? cand : win;
        end
        return win;
    endfunction

    assign winner_s      = rr_winner(hmaster_q, hbusreq);
    assign owner_lock_s  = hlock[hmaster_q];
    assign owner_req_s   = hbusreq[hmaster_q];
    assign fixed_burst_s = (hburst[2:1] != 2'b00);
    assign single_incr_s = (hburst[2:1] == 2'b00);

    assign rearb_s = hready && !owner_lock_s && (cnt_q <= 4'd1) &&
                     ((htrans == TR_IDLE) ||
                      ((htrans == TR_NONSEQ) && (hburst == 3'd0)) ||
                      ((htrans == TR_SEQ) && (state_q == ST_BURST) && (cnt_q == 4'd1)) ||
                      (htrans[1] && single_incr_s && !owner_req_s));

    // Next-state: burst tracking, rearbitration and output pipeline, all gated by hready.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        hgrant_d       = hgrant_q;
        hmastlock_d    = hmastlock_q;
        if (hready) begin
            hmaster_data_d = hmaster_q;
            if (state_q == ST_BURST) begin
                state_d = ST_BURST;
            end else begin
                state_d = owner_lock_s ? ST_LOCK : ST_ARB;
            end
            if (htrans == TR_NONSEQ) begin
                if (fixed_burst_s) begin
                    cnt_d   = burst_beats(hburst);
                    state_d = ST_BURST;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = owner_lock_s ? ST_LOCK : ST_ARB;
                end
            end else if ((htrans == TR_SEQ) && (state_q == ST_BURST) && (cnt_q != 4'd0)) begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = owner_lock_s ? ST_LOCK : ST_ARB;
                end else begin
                    state_d = ST_BURST;
                end
            end else begin
                cnt_d = cnt_q;
            end
            // A rearbitration discards any counter load made by the outgoing owner.
            if (rearb_s) begin
                hmaster_d = winner_s;
                cnt_d     = 4'd0;
                state_d   = hlock[winner_s] ? ST_LOCK : ST_ARB;
            end else begin
                hmaster_d = hmaster_q;
            end
            hgrant_d    = onehot(hmaster_d);
            hmastlock_d = hlock[hmaster_d];
        end else begin
            hmaster_d = hmaster_q;
        end
    end

    // State and output registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q        <= ST_ARB;
            cnt_q          <= 4'd0;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            hgrant_q       <= onehot(DEF_IDX);
            hmastlock_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hgrant_q       <= hgrant_d;
            hmastlock_q    <= hmastlock_d;
        end
    end

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Table-driven bench for ahb_arbiter: per-cycle vectors with hand-derived expected
// owner, data owner and lock, queued as a scoreboard and compared after each edge.
module tb_ahb_arbiter;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5, WRAP16 = 3'd6;
    localparam logic [3:0] ALL = 4'b1111;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       hmastlock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [1:0] m;
        logic [1:0] d;
        logic       ml;
    } vec_t;

    typedef struct {
        logic [1:0] m;
        logic [1:0] d;
        logic       ml;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    ahb_arbiter #(.NUM_MASTER(4), .DEFAULT_MASTER(0)) dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .hbusreq      (hbusreq),
        .hlock        (hlock),
        .htrans       (htrans),
        .hburst       (hburst),
        .hready       (hready),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hmastlock    (hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        logic [3:0] g;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sb.pop_front();
            g = 4'b0001 << e.m;
            chk({e.tag, ".hmaster"},      {30'd0, hmaster},      {30'd0, e.m});
            chk({e.tag, ".hgrant"},       {28'd0, hgrant},       {28'd0, g});
            chk({e.tag, ".hmaster_data"}, {30'd0, hmaster_data}, {30'd0, e.d});
            chk({e.tag, ".hmastlock"},    {31'd0, hmastlock},    {31'd0, e.ml});
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        hbusreq = v.req;
        hlock   = v.lock;
        htrans  = v.trans;
        hburst  = v.burst;
        hready  = v.ready;
        e.m = v.m; e.d = v.d; e.ml = v.ml; e.tag = tag;
        sb.push_back(e);
        @(posedge hclk);
        #1;
        compare_head();
    endtask

    function automatic void add(input logic [3:0] req, input logic [3:0] lock,
                                input logic [1:0] trans, input logic [2:0] burst,
                                input logic ready, input logic [1:0] m,
                                input logic [1:0] d, input logic ml);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = trans; v.burst = burst;
        v.ready = ready; v.m = m; v.d = d; v.ml = ml;
        vecs.push_back(v);
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic [1:0] trans,
                                input logic [2:0] burst, input logic [1:0] m,
                                input logic [1:0] d);
        vec_t v;
        v.req = req; v.lock = 4'b0000; v.trans = trans; v.burst = burst;
        v.ready = 1'b1; v.m = m; v.d = d; v.ml = 1'b0;
        return v;
    endfunction

    initial begin
        exp_t e;
        //   req      lock     trans  burst   rdy   m     d     ml
        // round robin over SINGLE transfers
        add(ALL,     4'b0000, NS,   SINGLE, 1'b1, 2'd1, 2'd0, 1'b0);
        add(ALL,     4'b0000, NS,   SINGLE, 1'b1, 2'd2, 2'd1, 1'b0);
        add(ALL,     4'b0000, NS,   SINGLE, 1'b1, 2'd3, 2'd2, 1'b0);
        add(ALL,     4'b0000, NS,   SINGLE, 1'b1, 2'd0, 2'd3, 1'b0);
        // master 1 INCR4 with a wait state on beat 3
        add(4'b0010, 4'b0000, NS,   SINGLE, 1'b1, 2'd1, 2'd0, 1'b0);
        add(ALL,     4'b0000, NS,   INCR4,  1'b1, 2'd1, 2'd1, 1'b0);
        add(ALL,     4'b0000, SQ,   INCR4,  1'b1, 2'd1, 2'd1, 1'b0);
        add(ALL,     4'b0000, SQ,   INCR4,  1'b0, 2'd1, 2'd1, 1'b0);
        add(ALL,     4'b0000, SQ,   INCR4,  1'b1, 2'd1, 2'd1, 1'b0);
        add(ALL,     4'b0000, SQ,   INCR4,  1'b1, 2'd2, 2'd1, 1'b0);
        add(ALL,     4'b0000, NS,   SINGLE, 1'b0, 2'd2, 2'd1, 1'b0);
        // master 3 INCR with BUSY, released by dropping its request
        add(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, 2'd3, 2'd2, 1'b0);
        add(ALL,     4'b0000, NS,   INCR,   1'b1, 2'd3, 2'd3, 1'b0);
        add(ALL,     4'b0000, BUSY, INCR,   1'b1, 2'd3, 2'd3, 1'b0);
        add(ALL,     4'b0000, SQ,   INCR,   1'b1, 2'd3, 2'd3, 1'b0);
        add(ALL,     4'b0000, BUSY, INCR,   1'b1, 2'd3, 2'd3, 1'b0);
        add(4'b0111, 4'b0000, SQ,   INCR,   1'b1, 2'd0, 2'd3, 1'b0);
        // master 2 locked across two SINGLEs
        add(4'b0100, 4'b0100, NS,   SINGLE, 1'b1, 2'd2, 2'd0, 1'b1);
        add(ALL,     4'b0100, NS,   SINGLE, 1'b1, 2'd2, 2'd2, 1'b1);
        add(ALL,     4'b0100, NS,   SINGLE, 1'b1, 2'd2, 2'd2, 1'b1);
        add(ALL,     4'b0000, NS,   SINGLE, 1'b1, 2'd3, 2'd2, 1'b0);
        // parking on the default master
        add(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 2'd0, 2'd3, 1'b0);
        add(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 2'd0, 2'd0, 1'b0);
        // WRAP16 cut short by INCR8: seven more beats before release
        add(ALL,     4'b0000, NS,   WRAP16, 1'b1, 2'd0, 2'd0, 1'b0);
        add(ALL,     4'b0000, SQ,   WRAP16, 1'b1, 2'd0, 2'd0, 1'b0);
        add(ALL,     4'b0000, NS,   INCR8,  1'b1, 2'd0, 2'd0, 1'b0);
        for (int k = 0; k < 6; k++) add(ALL, 4'b0000, SQ, INCR8, 1'b1, 2'd0, 2'd0, 1'b0);
        add(ALL,     4'b0000, SQ,   INCR8,  1'b1, 2'd1, 2'd0, 1'b0);
        // sole requester keeps the bus
        add(4'b0010, 4'b0000, NS,   SINGLE, 1'b1, 2'd1, 2'd1, 1'b0);

        hreset  = 1'b1;
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = IDLE;
        hburst  = SINGLE;
        hready  = 1'b1;
        #12;
        e.m = 2'd0; e.d = 2'd0; e.ml = 1'b0; e.tag = "reset";
        sb.push_back(e);
        compare_head();
        hreset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of a master 2 INCR4
        apply(mk(4'b0100, NS, SINGLE, 2'd2, 2'd1), "rst_setup0");
        apply(mk(ALL,     NS, INCR4,  2'd2, 2'd2), "rst_setup1");
        apply(mk(ALL,     SQ, INCR4,  2'd2, 2'd2), "rst_setup2");
        hreset = 1'b1;
        #1;
        e.m = 2'd0; e.d = 2'd0; e.ml = 1'b0; e.tag = "midburst_reset";
        sb.push_back(e);
        compare_head();
        hreset = 1'b0;
        // counter must be cleared: a SINGLE rearbitrates immediately
        apply(mk(ALL, NS, SINGLE, 2'd1, 2'd0), "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin bus arbiter for the multi-master AHB fabric.
- Decides which of NUM_MASTER masters drives the shared address/control phase, and tracks burst boundaries so that ownership changes only at legal points.
- Drives the address-phase mux select (hmaster), the data-phase mux select (hmaster_data), one-hot grants and hmastlock.
- Sits between the master interfaces and the address/write-data muxes feeding the decoder and slaves.

Parameters:
- NUM_MASTER, 4, number of requesting masters (2..16).
- MASTER_W, $clog2(NUM_MASTER), width of master index; derived, do not override.
- DEFAULT_MASTER, 0, parking master granted when no request is pending.

Ports:
- hclk, input, 1, bus clock; all state updates on rising edge.
- hreset, input, 1, asynchronous active-high reset.
- hbusreq, input, NUM_MASTER, per-master bus request.
- hlock, input, NUM_MASTER, per-master locked-transfer request.
- htrans, input, 2, transfer type of current address phase (muxed from owner): IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hburst, input, 3, burst type of current address phase: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16.
- hready, input, 1, bus-wide transfer-complete.
- hgrant, output, NUM_MASTER, one-hot grant, equal to decode of hmaster.
- hmaster, output, MASTER_W, current address-phase owner.
- hmaster_data, output, MASTER_W, current data-phase owner (write-data mux select).
- hmastlock, output, 1, current address phase is locked.

Behaviour:
- Reset (async, immediate, also mid-burst):
  - hmaster = hmaster_data = DEFAULT_MASTER; hgrant = onehot(DEFAULT_MASTER); hmastlock = 0.
  - Beat counter = 0; FSM = ARB.
- All registers update only on edges where hready=1; when hready=0, everything holds.
- FSM states:
  - ARB: owner at a rearbitration point.
  - BURST: fixed-length burst in progress.
  - LOCK: owner holds the bus via hlock.
- Beat counter cnt (4 bits), loaded on accepted NONSEQ (hready=1):
  - WRAP4/INCR4: cnt = 3.
  - WRAP8/INCR8: cnt = 7.
  - WRAP16/INCR16: cnt = 15.
  - Any NONSEQ load moves FSM to BURST.
- Accepted SEQ in BURST decrements cnt. An accepted NONSEQ while cnt>0 (early termination) reloads from the new hburst.
- Rearbitration point: edge with hready=1 AND hlock[hmaster]=0 AND any of:
  - (a) htrans=IDLE.
  - (b) htrans=NONSEQ with hburst=SINGLE.
  - (c) htrans=SEQ in BURST with cnt=1 (last beat).
  - (d) htrans in {NONSEQ, SEQ} with hburst in {SINGLE, INCR} and hbusreq[hmaster]=0.
- BUSY is never a rearbitration point. Neither is any point while cnt>1.
- Winner selection (combinational, applied at a rearbitration point):
  - Scan masters hmaster+1, hmaster+2, ... wrapping modulo NUM_MASTER, ending at hmaster itself; first with hbusreq=1 wins.
  - If no request is pending, winner = DEFAULT_MASTER.
  - Owner still requesting with no other requester keeps the bus.
- At a rearbitration edge: hmaster <= winner, hgrant <= onehot(winner), cnt <= 0. FSM <= LOCK if hlock[winner]=1, else ARB. If the same edge accepts a NONSEQ fixed burst by the old owner, the counter load is discarded.
- LOCK:
  - Arbitration is frozen while hlock[hmaster]=1.
  - After hlock[hmaster] drops, normal rules apply; a burst in progress is completed first (counter still tracked in LOCK).
- hmastlock <= hlock[next owner] on every hready=1 edge.
- hmaster_data <= hmaster on every hready=1 edge. This gives one-cycle address-to-data pipelining and holds through wait states.
- Latency: request to grant is 1 clock minimum, at the first rearbitration point.

Test Plan:
- Reset: assert hreset mid-BURST with hmaster=2 → same cycle hmaster=0, hgrant=0001, hmastlock=0, hmaster_data=0.
- Round-robin fairness: hbusreq=1111, all SINGLE NONSEQ, hready=1 → hmaster sequence 0,1,2,3,0; hmaster_data lags by one cycle.
- Fixed burst: master 1 issues INCR4 (NONSEQ+3 SEQ) while hbusreq=1111 → hmaster stays 1 for 4 accepted beats, then becomes 2. Insert hready=0 on beat 3 → no change until that beat is accepted.
- BUSY/INCR hold: master 3 issues INCR with BUSY cycles, hbusreq[3]=1 → no switch during BUSY. Drop hbusreq[3] on a SEQ beat → switch to 0 next edge.
- Lock: master 2 hlock=1 across two SINGLE transfers with others requesting → hmaster=2 and hmastlock=1 throughout. hlock drop → hmastlock=0 and switch to 3 at the next point.
- Parking: all hbusreq=0, htrans=IDLE → hmaster=DEFAULT_MASTER=0, hgrant=0001. Early termination: NONSEQ INCR8 after 2 beats of WRAP16 reloads cnt=7.
